// File: rtl/rvvi_retire_pkg.sv
// rvvi_retire_pkg: event layout and helpers shared by the retirement queue.
package rvvi_retire_pkg;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] pc_rdata;
        logic [31:0] insn;
        logic        trap;
        logic        debug_mode;
        logic [1:0]  mode;
        logic        x_wb_valid;
        logic [4:0]  x_wb_idx;
        logic [31:0] x_wdata;
    } event_t;

    localparam int EW = $bits(event_t);

    // Width of an event word for a given ILEN/XLEN; order is always the top 64 bits.
    function automatic int ev_width(input int ilen, input int xlen);
        return 64 + 2 * xlen + ilen + 10;
    endfunction

    function automatic int popcount(input logic [31:0] m);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) n += int'(m[i]);
        return n;
    endfunction

endpackage

// File: rtl/rvvi_retire_fifo.sv
// rvvi_retire_fifo: per-hart multi-write single-read event buffer with order checker.
module rvvi_retire_fifo
    import rvvi_retire_pkg::*;
#(
    parameter int W = EW,
    parameter int RETIRE = 2,
    parameter int DEPTH = 8,
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RETIRE-1:0]   valid,
    input  logic [RETIRE*W-1:0] data,
    input  logic                pop,
    input  logic                err_clear,
    output logic [W-1:0]        head,
    output logic [CW-1:0]       occupancy,
    output logic                overflow,
    output logic                gap_err
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [63:0]   expected, exp_n;
    logic          first_seen, seen_n, gap, accept;
    int            k;

    // Space is judged on registered occupancy only; a pop in the same cycle gives no credit.
    always_comb begin
        k = popcount(32'(valid));
        accept = (DEPTH - int'(occupancy)) >= k;
        exp_n = expected;
        seen_n = first_seen;
        gap = 1'b0;
        for (int r = 0; r < RETIRE; r++)
            if (accept && valid[r]) begin
                gap = gap | (seen_n && data[r*W+W-1 -: 64] != exp_n);
                exp_n = data[r*W+W-1 -: 64] + 64'd1;
                seen_n = 1'b1;
            end
    end

    always_ff @(posedge clk)
        if (accept)
            for (int r = 0; r < RETIRE; r++)
                if (valid[r])
                    mem[PW'((int'(wr_ptr) + popcount(32'(valid) & ((32'd1 << r) - 32'd1))) % DEPTH)] <= data[r*W +: W];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occupancy <= '0;
            expected <= '0;
            first_seen <= 1'b0;
            overflow <= 1'b0;
            gap_err <= 1'b0;
        end else begin
            wr_ptr <= accept ? PW'((int'(wr_ptr) + k) % DEPTH) : wr_ptr;
            rd_ptr <= pop ? PW'((int'(rd_ptr) + 1) % DEPTH) : rd_ptr;
            occupancy <= CW'(int'(occupancy) + (accept ? k : 0) - int'(pop));
            expected <= exp_n;
            first_seen <= seen_n;
            overflow <= (overflow & ~err_clear) | !accept;
            gap_err <= (gap_err & ~err_clear) | gap;
        end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/rvvi_retire_queue.sv
// rvvi_retire_queue: per-hart retirement FIFOs drained round-robin to a single valid/ready port.
module rvvi_retire_queue
    import rvvi_retire_pkg::*;
#(
    parameter int ILEN = 32,
    parameter int XLEN = 32,
    parameter int NHART = 2,
    parameter int RETIRE = 2,
    parameter int DEPTH = 8,
    localparam int W = ev_width(ILEN, XLEN),
    localparam int HW = NHART > 1 ? $clog2(NHART) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NHART*RETIRE-1:0]   in_valid,
    input  logic [NHART*RETIRE*W-1:0] in_event,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [HW-1:0]             out_hart,
    output logic [W-1:0]              out_event,
    output logic [NHART*CW-1:0]       occupancy,
    output logic [NHART-1:0]          overflow,
    output logic [NHART-1:0]          gap_err,
    input  logic                      err_clear
);

    logic [NHART-1:0] pop, busy;
    logic [W-1:0]     heads [NHART];
    logic [HW-1:0]    ptr, grant, idx;
    logic             found;

    for (genvar h = 0; h < NHART; h++) begin : g_hart
        rvvi_retire_fifo #(.W(W), .RETIRE(RETIRE), .DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .valid     (in_valid[h*RETIRE +: RETIRE]),
            .data      (in_event[h*RETIRE*W +: RETIRE*W]),
            .pop       (pop[h]),
            .err_clear (err_clear),
            .head      (heads[h]),
            .occupancy (occupancy[h*CW +: CW]),
            .overflow  (overflow[h]),
            .gap_err   (gap_err[h])
        );
        assign busy[h] = occupancy[h*CW +: CW] != '0;
        assign pop[h] = out_valid && out_ready && grant == HW'(h);
    end

    // First non-empty hart at or after the pointer, wrapping at NHART.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx = '0;
        for (int i = 0; i < NHART; i++) begin
            idx = HW'((int'(ptr) + i) % NHART);
            grant = (!found && busy[idx]) ? idx : grant;
            found = found | busy[idx];
        end
    end

    assign out_valid = |busy;
    assign out_hart = grant;
    assign out_event = out_valid ? heads[grant] : '0;

    always_ff @(posedge clk or posedge rst)
        if (rst) ptr <= '0;
        else if (out_valid && out_ready) ptr <= HW'((int'(grant) + 1) % NHART);

endmodule

// File: tb/tb_rvvi_retire_queue.sv
// tb_rvvi_retire_queue: directed self-checking bench for the retirement queue.
module tb_rvvi_retire_queue;
    import rvvi_retire_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     in_valid;
    logic [4*EW-1:0] in_event;
    logic           out_valid, out_ready, err_clear;
    logic [0:0]     out_hart;
    logic [EW-1:0]  out_event;
    logic [7:0]     occupancy;
    logic [1:0]     overflow, gap_err;
    int             checks = 0;
    int             errors = 0;

    rvvi_retire_queue #(.ILEN(32), .XLEN(32), .NHART(2), .RETIRE(2), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_event  (in_event),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hart  (out_hart),
        .out_event (out_event),
        .occupancy (occupancy),
        .overflow  (overflow),
        .gap_err   (gap_err),
        .err_clear (err_clear)
    );

    always #5 clk = ~clk;

    function automatic event_t mk(input int o);
        event_t e;
        e = '0;
        e.order = 64'(o);
        e.pc_rdata = 32'h8000_0000 + {o[29:0], 2'b00};
        e.insn = 32'h13 ^ o;
        e.mode = 2'b11;
        e.x_wb_valid = 1'b1;
        e.x_wb_idx = o[4:0];
        e.x_wdata = ~o;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic lane(input int h, input int r, input int o);
        in_valid[h*2+r] = 1'b1;
        in_event[(h*2+r)*EW +: EW] = mk(o);
    endtask

    task automatic clr();
        in_valid = '0;
        in_event = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        err_clear = 1'b0;
        clr();
        #2;
        chk("rst_valid", 256'(out_valid), 256'(0));
        chk("rst_occ", 256'(occupancy), 256'(0));
        chk("rst_ovf", 256'(overflow), 256'(0));
        chk("rst_gap", 256'(gap_err), 256'(0));
        chk("rst_hart", 256'(out_hart), 256'(0));
        chk("rst_event", 256'(out_event), 256'(0));
        tick();
        tick();
        rst = 1'b0;
        // two lanes on hart0, consumer ready
        lane(0, 0, 10);
        lane(0, 1, 11);
        out_ready = 1'b1;
        chk("same_cycle_invisible", 256'(out_valid), 256'(0));
        tick();
        clr();
        chk("t1_valid", 256'(out_valid), 256'(1));
        chk("t1_hart", 256'(out_hart), 256'(0));
        chk("t1_ev10", 256'(out_event), 256'(mk(10)));
        chk("t1_occ", 256'(occupancy[3:0]), 256'(2));
        tick();
        chk("t1_ev11", 256'(out_event), 256'(mk(11)));
        tick();
        chk("t1_empty", 256'(out_valid), 256'(0));
        chk("t1_gap", 256'(gap_err), 256'(0));
        // lane1 only, order 5 while 12 expected: stored, gap flagged
        lane(0, 1, 5);
        tick();
        clr();
        chk("t2_occ", 256'(occupancy[3:0]), 256'(1));
        chk("t2_ev5", 256'(out_event), 256'(mk(5)));
        chk("t2_gap", 256'(gap_err), 256'(1));
        tick();
        chk("t2_drained", 256'(occupancy[3:0]), 256'(0));
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("t2_clear", 256'(gap_err), 256'(0));
        // fill hart1 then overflow
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lane(1, 0, 2 * i);
            lane(1, 1, 2 * i + 1);
            tick();
            clr();
            if (i == 0) chk("t3_occ2", 256'(occupancy[7:4]), 256'(2));
        end
        chk("t3_full", 256'(occupancy[7:4]), 256'(8));
        chk("t3_no_ovf", 256'(overflow), 256'(0));
        lane(1, 0, 8);
        lane(1, 1, 9);
        tick();
        clr();
        chk("t3_occ_kept", 256'(occupancy[7:4]), 256'(8));
        chk("t3_ovf", 256'(overflow), 256'(2));
        lane(1, 0, 8);
        lane(1, 1, 9);
        out_ready = 1'b1;
        chk("t3_hart", 256'(out_hart), 256'(1));
        chk("t3_ev0", 256'(out_event), 256'(mk(0)));
        tick();
        clr();
        chk("t3_no_credit", 256'(occupancy[7:4]), 256'(7));
        for (int i = 1; i < 8; i++) begin
            chk("t3_drain", 256'(out_event), 256'(mk(i)));
            tick();
        end
        chk("t3_empty", 256'(out_valid), 256'(0));
        chk("t3_gap", 256'(gap_err), 256'(0));
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("t3_ovf_clear", 256'(overflow), 256'(0));
        // hart0 expects 6: 6,7 fine, 10 gaps, 11 fine after resync
        out_ready = 1'b0;
        lane(0, 0, 6);
        lane(0, 1, 7);
        tick();
        clr();
        chk("t4_no_gap", 256'(gap_err), 256'(0));
        lane(0, 0, 10);
        tick();
        clr();
        chk("t4_gap", 256'(gap_err), 256'(1));
        chk("t4_occ", 256'(occupancy[3:0]), 256'(3));
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("t4_clear", 256'(gap_err), 256'(0));
        lane(0, 0, 11);
        tick();
        clr();
        chk("t4_resync", 256'(gap_err), 256'(0));
        lane(0, 0, 20);
        err_clear = 1'b1;
        tick();
        clr();
        err_clear = 1'b0;
        chk("t4_err_wins", 256'(gap_err), 256'(1));
        chk("t4_occ5", 256'(occupancy[3:0]), 256'(5));
        // async reset mid-burst
        rst = 1'b1;
        #1;
        chk("t6_valid", 256'(out_valid), 256'(0));
        chk("t6_occ", 256'(occupancy), 256'(0));
        chk("t6_gap", 256'(gap_err), 256'(0));
        chk("t6_ovf", 256'(overflow), 256'(0));
        chk("t6_event", 256'(out_event), 256'(0));
        tick();
        rst = 1'b0;
        tick();
        chk("t6_still_empty", 256'(out_valid), 256'(0));
        // both harts hold three events; drain alternates starting at hart0
        lane(0, 0, 100);
        lane(0, 1, 101);
        lane(1, 0, 50);
        lane(1, 1, 51);
        tick();
        clr();
        lane(0, 0, 102);
        lane(1, 1, 52);
        tick();
        clr();
        chk("t5_gap", 256'(gap_err), 256'(0));
        chk("t5_occ", 256'(occupancy), 256'(8'h33));
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("t5_hart", 256'(out_hart), 256'(i % 2));
            chk("t5_event", 256'(out_event), 256'(mk(i % 2 == 0 ? 100 + i / 2 : 50 + i / 2)));
            tick();
        end
        chk("t5_empty", 256'(out_valid), 256'(0));
        chk("t5_gap_end", 256'(gap_err), 256'(0));
        chk("t5_ovf_end", 256'(overflow), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvvi_retire_queue.md
Name: rvvi_retire_queue

Overview:
- Parametrised retirement-event buffer for the RVVI trace path.
- Accepts up to RETIRE retired events per hart per clock from NHART harts and stores them in per-hart FIFOs of DEPTH entries.
- Checks that each hart's event order count is gap-free and drains events one per cycle, round-robin across harts, over a valid/ready port.
- Sits between the core's RVVI trace taps and the reference-model comparator, decoupling multi-retire bursts from a single-event consumer.

Parameters:
- ILEN, 32, instruction width in bits
- XLEN, 32, GPR and PC width in bits
- NHART, 2, number of harts (1..8)
- RETIRE, 2, events per hart per cycle (1..4)
- DEPTH, 8, FIFO entries per hart (power of two, >= RETIRE)

Ports:
- clk  in  1  interface clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  NHART*RETIRE  per-lane valid event; index h*RETIRE+r
- in_event  in  NHART*RETIRE*EW  per-lane event payload (EW from package)
- out_valid  out  1  head event available
- out_ready  in  1  consumer accepts out_event this cycle
- out_hart  out  $clog2(NHART) (min 1)  hart of out_event
- out_event  out  EW  event payload
- occupancy  out  NHART*($clog2(DEPTH)+1)  per-hart entry count
- overflow  out  NHART  sticky: a group was dropped for lack of space
- gap_err  out  NHART  sticky: order discontinuity detected
- err_clear  in  1  synchronous clear of overflow and gap_err

Behaviour:
- Reset (async, rst=1): all FIFOs empty; occupancy=0; out_valid=0; out_hart=0; out_event=0; overflow=0; gap_err=0; first_seen=0 per hart; round-robin pointer=0.
- Push, per hart, per cycle:
  - k = number of asserted in_valid lanes.
  - Lanes are compacted in ascending lane order; holes are permitted and skipped.
  - Accept only if DEPTH - occupancy >= k. Occupancy is the registered value; a same-cycle pop gives no credit.
  - Otherwise drop all k events and set overflow[h]. Dropped events do not update the expected order.
- Order check, per accepted event in lane order:
  - If first_seen=0: expected = order+1, first_seen=1.
  - Else if order != expected: set gap_err[h], expected = order+1 (resync). The event is still stored.
  - Else expected = expected+1. Arithmetic is 64-bit and wraps modulo 2^64.
- Latency: an event pushed in cycle N is eligible at the output in cycle N+1 at the earliest.
- Output: out_valid=1 when any FIFO is non-empty. The grant goes to the first non-empty hart at or after the round-robin pointer, wrapping at NHART.
  - out_hart/out_event come from the granted head, combinationally from FIFO storage.
  - They stay stable while out_valid=1 and out_ready=0 unless a higher-priority hart becomes non-empty; the grant is recomputed every cycle.
- Handshake: when out_valid and out_ready are both 1, pop the granted head and set the pointer to granted+1 mod NHART.
- Simultaneous push and pop on one hart: both take effect; occupancy = occ - 1 + k.
- err_clear=1 clears both sticky vectors; a new error detected in the same cycle wins (flag stays set).
- Reset mid-burst discards all contents. No partial events are emitted afterwards.

Decomposition:
- Package rvvi_retire_pkg:
  - event_t packed struct: order[63:0], pc_rdata[XLEN-1:0], insn[ILEN-1:0], trap, debug_mode, mode[1:0], x_wb_valid, x_wb_idx[4:0], x_wdata[XLEN-1:0].
  - EW = $bits(event_t).
  - Helper function popcount for lane masks.
- Sub-module rvvi_retire_fifo, instantiated NHART times:
  - Multi-write (RETIRE ports), single-read circular buffer.
  - Holds wr/rd pointers, occupancy, the order checker and the sticky flags.
- The top level holds the round-robin arbiter and output mux.

Test Plan:
- NHART=2, RETIRE=2, DEPTH=8: hart0 lanes 0,1 with order 10,11 in cycle 1, out_ready=1 -> cycle 2 out_event.order=10, hart0; cycle 3 order=11; gap_err=0.
- Hart0 lane 1 only, order 5 (lane 0 idle) -> stored as single event; occupancy[0]=1; order 5 emitted next cycle.
- out_ready=0, hart1 pushes 2 events/cycle for 4 cycles -> occupancy[1]=8. Fifth cycle pushes order 8,9 -> dropped, overflow[1]=1, occupancy stays 8. Drain yields orders 0..7.
- Hart0 orders 3, 4, 7 -> gap_err[0]=1 after order 7; all three emitted. err_clear pulse -> gap_err[0]=0. Order 8 next -> no error.
- Both harts hold 3 events, out_ready=1 -> out_hart sequence 0,1,0,1,0,1.
- rst asserted while occupancy=5 -> next cycle out_valid=0, occupancy=0, flags 0. First post-reset event with order 100 -> no gap_err.
